button_debouncer: RTL and testbench
===================================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, number of cycles the synchronized input must be stable before a level change (10 ms at 100 MHz).
REQ-002 SHALL have parameter LONG_CYCLES, default 100_000_000, number of cycles held after press_pulse before long_press fires (1 s at 100 MHz).
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port button_in  input  1  raw, asynchronous, bouncing push-button.
REQ-006 SHALL have port button_level  output  1  debounced button state, 1 = pressed.
REQ-007 SHALL have port press_pulse  output  1  one-cycle strobe on debounced press, intended to drive the LED mode controller's button input.
REQ-008 SHALL have port release_pulse  output  1  one-cycle strobe on debounced release.
REQ-009 SHALL have port long_press  output  1  one-cycle strobe when a press has been held LONG_CYCLES.
REQ-010 SHALL have port press_count  output  8  count of debounced presses since reset.

Function
REQ-011 SHALL pass button_in through a two-flop synchronizer; only the second flop output (sync) SHALL feed any other logic.
REQ-012 SHALL implement FSM states IDLE (released, stable), PRESS_WAIT, PRESSED (stable), RELEASE_WAIT.
REQ-013 IDLE -> PRESS_WAIT when sync=1; debounce counter cleared on entry.
REQ-014 PRESS_WAIT: sync=0 on any cycle -> IDLE, counter cleared, no output; sync=1 for DEBOUNCE_CYCLES consecutive cycles -> PRESSED.
REQ-015 PRESSED -> RELEASE_WAIT when sync=0; counter cleared on entry.
REQ-016 RELEASE_WAIT: sync=1 on any cycle -> PRESSED, no output; sync=0 for DEBOUNCE_CYCLES consecutive cycles -> IDLE.
REQ-017 All outputs SHALL be registered; button_level=1 exactly in states PRESSED and RELEASE_WAIT.
REQ-018 Latency: if button_in is first sampled 1 at edge N and stays 1, press_pulse and button_level rise after edge N+1+DEBOUNCE_CYCLES; release symmetric with release_pulse.
REQ-019 press_pulse SHALL be high exactly one cycle per PRESS_WAIT->PRESSED transition; release_pulse exactly one cycle per RELEASE_WAIT->IDLE transition.
REQ-020 Hold counter SHALL clear on press_pulse, increment every cycle in PRESSED and RELEASE_WAIT, saturate at LONG_CYCLES.
REQ-021 long_press SHALL pulse one cycle when the hold counter reaches LONG_CYCLES; at most once per press; never if released earlier.
REQ-022 Bounce during RELEASE_WAIT returning to PRESSED SHALL NOT restart the hold counter nor re-fire press_pulse.
REQ-023 press_count SHALL increment by 1 in the cycle press_pulse is high, wrapping 255 -> 0.
REQ-024 Counter widths SHALL be $clog2 of their terminal value +1; DEBOUNCE_CYCLES >= 2 and LONG_CYCLES > DEBOUNCE_CYCLES are required parameter constraints.

Reset
REQ-025 On rst=1 at a clock edge: state=IDLE, synchronizer flops=0, all counters=0, button_level=0, press_pulse=0, release_pulse=0, long_press=0, press_count=0.
REQ-026 Reset mid-press SHALL abort all pending strobes; a button held through reset release SHALL be re-debounced and produce a fresh press_pulse after REQ-018 latency.
REQ-027 rst SHALL take priority over all state transitions in the same cycle.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-028 Clean press, button_in 0->1 held 30 cycles -> press_pulse one cycle at N+5, press_count=1, long_press one cycle 20 cycles after press_pulse, button_level=1.
REQ-029 Glitch: button_in high 3 cycles then low -> no press_pulse, button_level stays 0, press_count=0.
REQ-030 Bouncing press: 1,0,1,0,1 toggles then steady 1 -> exactly one press_pulse, 4+2 cycles after last rising toggle.
REQ-031 Release bounce: held, then 0 for 2 cycles, 1 again, then steady 0 -> single release_pulse after steady 0 debounce, no second press_pulse.
REQ-032 256 clean press/release cycles -> press_count wraps to 0, 256 press_pulse and 256 release_pulse strobes.
REQ-033 rst asserted 2 cycles while PRESSED with button held -> all outputs 0 during reset; new press_pulse 6 cycles after rst release, press_count=1.

Source files
------------

// File: rtl/button_debouncer.sv
// Push-button conditioner: two-flop synchronizer, debounce FSM,
// press/release/long-press strobes and a wrapping press counter.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_in,
  output logic       button_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_press,
  output logic [7:0] press_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int LW = $clog2(LONG_CYCLES) + 1;

  // The IDLE/PRESSED sample that opens a wait state counts as the first
  // stable cycle, so the wait state needs DEBOUNCE_CYCLES-1 more.
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 2);
  localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_e;

  logic          meta_q, sync_q;
  state_e        state_q, state_d;
  logic [DW-1:0] db_q, db_d;
  logic [LW-1:0] hold_q, hold_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          long_q, long_d;
  logic [7:0]    count_q, count_d;
  logic          held;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      state_q <= IDLE;
      db_q    <= '0;
      hold_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      count_q <= '0;
    end else begin
      meta_q  <= button_in;
      sync_q  <= meta_q;
      state_q <= state_d;
      db_q    <= db_d;
      hold_q  <= hold_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    db_d    = db_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sync_q) begin
          state_d = PRESS_WAIT;
          db_d    = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync_q) begin
          state_d = IDLE;
          db_d    = '0;
        end else if (db_q == DB_LAST) begin
          state_d = PRESSED;
          press_d = 1'b1;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!sync_q) begin
          state_d = RELEASE_WAIT;
          db_d    = '0;
        end
      end
      RELEASE_WAIT: begin
        if (sync_q) begin
          state_d = PRESSED;
        end else if (db_q == DB_LAST) begin
          state_d = IDLE;
          rel_d   = 1'b1;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign held = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

  always_comb begin
    hold_d  = hold_q;
    long_d  = 1'b0;
    count_d = count_q;
    level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    if (press_d) begin
      hold_d  = '0;
      count_d = count_q + 8'd1;
    end else if (held && hold_q != LONG_MAX) begin
      hold_d = hold_q + 1'b1;
    end
    // Saturation keeps long_press to a single strobe per press.
    long_d = (hold_d == LONG_MAX) && (hold_q != LONG_MAX);
  end

  assign button_level  = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_press    = long_q;
  assign press_count   = count_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with
// DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
module tb_button_debouncer;

  logic       clk = 1'b0;
  logic       rst;
  logic       button_in;
  logic       button_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_press;
  logic [7:0] press_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_press = 0, n_rel = 0, n_long = 0;
  int last_press = -1, last_rel = -1, last_long = -1;

  button_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .button_in(button_in),
    .button_level(button_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_press(long_press),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: one increment per high cycle, stamped with edge index.
  always @(negedge clk) begin
    if (press_pulse === 1'b1) begin
      n_press++;
      last_press = cyc;
    end
    if (release_pulse === 1'b1) begin
      n_rel++;
      last_rel = cyc;
    end
    if (long_press === 1'b1) begin
      n_long++;
      last_long = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    button_in = 1'b1;
    tick(3);
    checks++;
    if (button_level !== 1'b0) begin
      errors++;
      $display("FAIL reset_level got=%b want=0", button_level);
    end
    checks++;
    if ({press_pulse, release_pulse, long_press} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes got=%b want=000",
               {press_pulse, release_pulse, long_press});
    end
    checks++;
    if (press_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_count got=%0d want=0", press_count);
    end
    button_in = 1'b0;
    rst = 1'b0;
    tick(8);
    checks++;
    if (n_press !== 0 || button_level !== 1'b0) begin
      errors++;
      $display("FAIL reset_quiet got=%0d/%b want=0/0", n_press, button_level);
    end
  endtask

  task automatic test_glitch;
    int p0;
    p0 = n_press;
    button_in = 1'b1;
    tick(3);
    button_in = 1'b0;
    checks++;
    if (button_level !== 1'b0) begin
      errors++;
      $display("FAIL glitch_level_mid got=%b want=0", button_level);
    end
    tick(12);
    checks++;
    if (n_press - p0 !== 0) begin
      errors++;
      $display("FAIL glitch_press got=%0d want=0", n_press - p0);
    end
    checks++;
    if (button_level !== 1'b0 || press_count !== 8'd0) begin
      errors++;
      $display("FAIL glitch_state got=%b/%0d want=0/0",
               button_level, press_count);
    end
  endtask

  task automatic test_clean_press;
    int n, m, p0, r0, l0;
    p0 = n_press; r0 = n_rel; l0 = n_long;
    n = cyc + 1;
    button_in = 1'b1;
    tick(30);
    checks++;
    if (n_press - p0 !== 1 || last_press !== n + 5) begin
      errors++;
      $display("FAIL clean_press got=%0d@%0d want=1@%0d",
               n_press - p0, last_press, n + 5);
    end
    checks++;
    if (n_long - l0 !== 1 || last_long !== n + 25) begin
      errors++;
      $display("FAIL clean_long got=%0d@%0d want=1@%0d",
               n_long - l0, last_long, n + 25);
    end
    checks++;
    if (button_level !== 1'b1 || press_count !== 8'd1) begin
      errors++;
      $display("FAIL clean_state got=%b/%0d want=1/1",
               button_level, press_count);
    end
    m = cyc + 1;
    button_in = 1'b0;
    tick(12);
    checks++;
    if (n_rel - r0 !== 1 || last_rel !== m + 5) begin
      errors++;
      $display("FAIL clean_release got=%0d@%0d want=1@%0d",
               n_rel - r0, last_rel, m + 5);
    end
    checks++;
    if (button_level !== 1'b0) begin
      errors++;
      $display("FAIL clean_level_off got=%b want=0", button_level);
    end
  endtask

  task automatic test_min_press;
    int n, p0, r0, l0;
    p0 = n_press; r0 = n_rel; l0 = n_long;
    n = cyc + 1;
    button_in = 1'b1;
    tick(4);
    button_in = 1'b0;
    tick(14);
    checks++;
    if (n_press - p0 !== 1 || last_press !== n + 5) begin
      errors++;
      $display("FAIL min_press got=%0d@%0d want=1@%0d",
               n_press - p0, last_press, n + 5);
    end
    checks++;
    if (n_rel - r0 !== 1 || last_rel !== n + 9) begin
      errors++;
      $display("FAIL min_release got=%0d@%0d want=1@%0d",
               n_rel - r0, last_rel, n + 9);
    end
    checks++;
    if (n_long - l0 !== 0 || press_count !== 8'd2) begin
      errors++;
      $display("FAIL min_long_count got=%0d/%0d want=0/2",
               n_long - l0, press_count);
    end
  endtask

  task automatic test_bounce_press;
    int l, p0;
    logic [4:0] pat;
    p0 = n_press;
    pat = 5'b10101;
    for (int i = 4; i >= 0; i--) begin
      button_in = pat[i];
      if (i == 0) l = cyc + 1;
      tick(1);
    end
    tick(15);
    checks++;
    if (n_press - p0 !== 1 || last_press !== l + 5) begin
      errors++;
      $display("FAIL bounce_press got=%0d@%0d want=1@%0d",
               n_press - p0, last_press, l + 5);
    end
    button_in = 1'b0;
    tick(12);
  endtask

  task automatic test_release_bounce;
    int n, z, s, p0, r0, l0;
    p0 = n_press; r0 = n_rel; l0 = n_long;
    n = cyc + 1;
    button_in = 1'b1;
    tick(8);
    z = cyc + 1;
    button_in = 1'b0;
    tick(2);
    button_in = 1'b1;
    tick(4);
    checks++;
    if (button_level !== 1'b1 || n_rel - r0 !== 0) begin
      errors++;
      $display("FAIL relb_hold got=%b/%0d want=1/0",
               button_level, n_rel - r0);
    end
    tick(n + 30 - z - 6);
    checks++;
    if (n_long - l0 !== 1 || last_long !== n + 25) begin
      errors++;
      $display("FAIL relb_long got=%0d@%0d want=1@%0d",
               n_long - l0, last_long, n + 25);
    end
    s = cyc + 1;
    button_in = 1'b0;
    tick(12);
    checks++;
    if (n_rel - r0 !== 1 || last_rel !== s + 5) begin
      errors++;
      $display("FAIL relb_release got=%0d@%0d want=1@%0d",
               n_rel - r0, last_rel, s + 5);
    end
    checks++;
    if (n_press - p0 !== 1) begin
      errors++;
      $display("FAIL relb_no_repress got=%0d want=1", n_press - p0);
    end
  endtask

  task automatic test_reset_mid_press;
    int n, r, p0, l0;
    n = cyc + 1;
    button_in = 1'b1;
    tick(20);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      checks++;
      if ({button_level, press_pulse, release_pulse, long_press} !== 4'b0
          || press_count !== 8'd0) begin
        errors++;
        $display("FAIL rstmid_outputs got=%b/%0d want=0000/0",
                 {button_level, press_pulse, release_pulse, long_press},
                 press_count);
      end
    end
    p0 = n_press; l0 = n_long;
    rst = 1'b0;
    r = cyc + 1;
    tick(24);
    checks++;
    if (n_press - p0 !== 1 || last_press !== r + 5) begin
      errors++;
      $display("FAIL rstmid_press got=%0d@%0d want=1@%0d",
               n_press - p0, last_press, r + 5);
    end
    checks++;
    if (n_long - l0 !== 0 || press_count !== 8'd1) begin
      errors++;
      $display("FAIL rstmid_abort got=%0d/%0d want=0/1",
               n_long - l0, press_count);
    end
    tick(3);
    checks++;
    if (n_long - l0 !== 1 || last_long !== r + 25) begin
      errors++;
      $display("FAIL rstmid_long got=%0d@%0d want=1@%0d",
               n_long - l0, last_long, r + 25);
    end
    if (n < 0) $display("n=%0d", n);
    button_in = 1'b0;
    tick(12);
  endtask

  task automatic test_wrap;
    int p0, r0;
    rst = 1'b1;
    button_in = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(2);
    p0 = n_press; r0 = n_rel;
    for (int i = 0; i < 256; i++) begin
      button_in = 1'b1;
      tick(8);
      button_in = 1'b0;
      tick(8);
      if (i == 254) begin
        checks++;
        if (press_count !== 8'd255) begin
          errors++;
          $display("FAIL wrap_255 got=%0d want=255", press_count);
        end
      end
    end
    checks++;
    if (press_count !== 8'd0) begin
      errors++;
      $display("FAIL wrap_count got=%0d want=0", press_count);
    end
    checks++;
    if (n_press - p0 !== 256 || n_rel - r0 !== 256) begin
      errors++;
      $display("FAIL wrap_strobes got=%0d/%0d want=256/256",
               n_press - p0, n_rel - r0);
    end
  endtask

  initial begin
    rst = 1'b1;
    button_in = 1'b0;
    test_reset;
    test_glitch;
    test_clean_press;
    test_min_press;
    test_bounce_press;
    test_release_bounce;
    test_reset_mid_press;
    test_wrap;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
